// File: rtl/scan_pkg.sv
// Shared definitions for the channel scan sequencer: FSM states and channel geometry.
package scan_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        STEP  = 2'd2
    } scan_state_e;

    // Search start point used when leaving IDLE. Searching ascending from the top channel
    // lands on the lowest set bit; searching descending from channel 0 lands on the highest.
    function automatic logic [SEL_W-1:0] scan_start(input logic dir);
        return dir ? SEL_W'(0) : SEL_W'(NUM_CH - 1);
    endfunction

endpackage

// File: rtl/scan_next_ch.sv
// Combinational next-channel search: finds the next set mask bit after cur in direction
// dir with modulo-8 wrap-around. cur itself is only chosen when it is the sole set bit.
module scan_next_ch
    import scan_pkg::*;
(
    input  logic [SEL_W-1:0]  cur,
    input  logic              dir,
    input  logic [NUM_CH-1:0] mask,
    output logic [SEL_W-1:0]  next,
    output logic              wrapped
);

    logic             found;
    logic [SEL_W-1:0] cand;

    // Walk offsets 1..NUM_CH; offset NUM_CH aliases to cur, so a lone channel re-selects itself.
    always_comb begin
        found = 1'b0;
        next  = cur;
        cand  = cur;
        for (int k = 1; k <= int'(NUM_CH); k++) begin
            cand = dir ? (cur - SEL_W'(k)) : (cur + SEL_W'(k));
            if (!found && mask[cand]) begin
                found = 1'b1;
                next  = cand;
            end
        end
    end

    // An advance wraps when it does not move strictly forward in the scan direction.
    always_comb begin
        wrapped = dir ? (next >= cur) : (next <= cur);
    end

endmodule

// File: rtl/scan_sequencer.sv
// Channel scan sequencer: cycles sel through the enabled channels of ch_mask, holding each
// for dwell+1 cycles. The STEP state is the first cycle on a newly selected channel.
// Optional feature: define SCAN_FRAME_CNT_EN to add the frame_cnt output (wrap counter).
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NUM_CH-1:0]  ch_mask,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               step_pulse,
    output logic               wrap
`ifdef SCAN_FRAME_CNT_EN
    ,
    output logic [7:0]         frame_cnt
`endif
);

    scan_state_e        state;
    logic [DWELL_W-1:0] counter;
    logic [SEL_W-1:0]   search_cur;
    logic [SEL_W-1:0]   next_ch;
    logic               next_wrapped;
    logic               run_ok;
    logic               dwell_done;

    // Leaving IDLE the search starts just outside the scan order so it lands on the first channel.
    always_comb begin
        search_cur = (state == IDLE) ? scan_start(dir) : sel;
        run_ok     = en && (ch_mask != '0);
        dwell_done = (counter == dwell);
    end

    scan_next_ch u_next_ch (
        .cur     (search_cur),
        .dir     (dir),
        .mask    (ch_mask),
        .next    (next_ch),
        .wrapped (next_wrapped)
    );

    // Scan FSM with registered sel, counter and pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= '0;
            sel_valid  <= 1'b0;
            step_pulse <= 1'b0;
            wrap       <= 1'b0;
            counter    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    step_pulse <= 1'b0;
                    wrap       <= 1'b0;
                    counter    <= '0;
                    if (run_ok) begin
                        state     <= DWELL;
                        sel       <= next_ch;
                        sel_valid <= 1'b1;
                    end else begin
                        sel       <= '0;
                        sel_valid <= 1'b0;
                    end
                end
                DWELL, STEP: begin
                    if (!run_ok) begin
                        // Disable wins over a step falling due in the same cycle.
                        state      <= IDLE;
                        sel        <= '0;
                        sel_valid  <= 1'b0;
                        step_pulse <= 1'b0;
                        wrap       <= 1'b0;
                        counter    <= '0;
                    end else if (dwell_done) begin
                        state      <= STEP;
                        sel        <= next_ch;
                        step_pulse <= 1'b1;
                        wrap       <= next_wrapped;
                        counter    <= '0;
                    end else begin
                        state      <= DWELL;
                        step_pulse <= 1'b0;
                        wrap       <= 1'b0;
                        counter    <= counter + DWELL_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    sel        <= '0;
                    sel_valid  <= 1'b0;
                    step_pulse <= 1'b0;
                    wrap       <= 1'b0;
                    counter    <= '0;
                end
            endcase
        end
    end

`ifdef SCAN_FRAME_CNT_EN
    // Frame counter: counts wrap advances, held at zero while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (state == IDLE) begin
            frame_cnt <= '0;
        end else if (run_ok && dwell_done && next_wrapped) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: channel-level reference model checked every cycle, plus directed
// literal sequences. Inputs change on the falling edge; outputs are compared on it too.
module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic [7:0] ch_mask = 8'd0;
    logic [2:0] sel;
    logic       sel_valid;
    logic       step_pulse;
    logic       wrap;
`ifdef SCAN_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: which channel is shown and how many cycles it has been shown.
    bit m_active = 1'b0;
    int m_ch     = 0;
    int m_age    = 0;
    bit m_step   = 1'b0;
    bit m_wrap   = 1'b0;
    int m_frame  = 0;

    scan_sequencer #(.DWELL_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .dir        (dir),
        .dwell      (dwell),
        .ch_mask    (ch_mask),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .step_pulse (step_pulse),
        .wrap       (wrap)
`ifdef SCAN_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int first_ch(input logic [7:0] m, input logic d);
        int r = 0;
        if (!d) begin
            for (int i = 7; i >= 0; i--) if (m[i]) r = i;
        end else begin
            for (int i = 0; i < 8; i++) if (m[i]) r = i;
        end
        return r;
    endfunction

    // Next channel by "strictly beyond cur, else start over from the far end".
    task automatic next_ch(input logic [7:0] m, input logic d, input int cur,
                           output int nxt, output bit wr);
        int best = -1;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                if (!d && i > cur && (best < 0 || i < best)) best = i;
                if (d && i < cur && (best < 0 || i > best)) best = i;
            end
        end
        wr  = (best < 0);
        nxt = wr ? first_ch(m, d) : best;
    endtask

    task automatic model_idle();
        m_active = 1'b0;
        m_ch     = 0;
        m_age    = 0;
        m_step   = 1'b0;
        m_wrap   = 1'b0;
        m_frame  = 0;
    endtask

    task automatic model_step();
        int nxt;
        bit wr;
        if (!rst_n) begin
            model_idle();
        end else if (!m_active) begin
            if (en && ch_mask != 8'd0) begin
                m_active = 1'b1;
                m_ch     = first_ch(ch_mask, dir);
                m_age    = 0;
            end
            m_step = 1'b0;
            m_wrap = 1'b0;
        end else if (!en || ch_mask == 8'd0) begin
            model_idle();
        end else if (m_age == int'(dwell)) begin
            next_ch(ch_mask, dir, m_ch, nxt, wr);
            m_ch    = nxt;
            m_step  = 1'b1;
            m_wrap  = wr;
            m_age   = 0;
            m_frame = wr ? (m_frame + 1) % 256 : m_frame;
        end else begin
            m_age  = m_age + 1;
            m_step = 1'b0;
            m_wrap = 1'b0;
        end
    endtask

    // Every-cycle compare against the model.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (!rst_n) model_idle();
            chk("m_sel", int'(sel), m_active ? m_ch : 0);
            chk("m_valid", int'(sel_valid), int'(m_active));
            chk("m_step", int'(step_pulse), int'(m_step));
            chk("m_wrap", int'(wrap), int'(m_wrap));
`ifdef SCAN_FRAME_CNT_EN
            chk("m_frame", int'(frame_cnt), m_frame);
`endif
        end
    end

    task automatic set_in(input logic e, input logic d, input logic [7:0] dw,
                          input logic [7:0] m);
        en      = e;
        dir     = d;
        dwell   = dw;
        ch_mask = m;
    endtask

    task automatic go_idle();
        en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    int exp_sel_29 [4]  = '{7, 5, 2, 7};
    int exp_step_29 [4] = '{0, 1, 1, 1};
    int exp_wrap_29 [4] = '{0, 0, 0, 1};

    initial begin
        int es;
        int est;
        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_sel", int'(sel), 0);
        chk("rst_valid", int'(sel_valid), 0);
        #3 rst_n = 1'b1;
        @(negedge clk);

        // Full mask ascending, dwell 2: each channel 3 cycles, wrap only on 7->0.
        set_in(1'b1, 1'b0, 8'd2, 8'hFF);
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk);
            es  = ((k - 1) / 3) % 8;
            est = (k > 1 && (k - 1) % 3 == 0) ? 1 : 0;
            chk("ff_sel", int'(sel), es);
            chk("ff_step", int'(step_pulse), est);
            chk("ff_wrap", int'(wrap), (est == 1 && es == 0) ? 1 : 0);
        end
        go_idle();

        // Sparse mask descending, dwell 0: 7,5,2,7.
        set_in(1'b1, 1'b1, 8'd0, 8'b1010_0100);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("desc_sel", int'(sel), exp_sel_29[k]);
            chk("desc_step", int'(step_pulse), exp_step_29[k]);
            chk("desc_wrap", int'(wrap), exp_wrap_29[k]);
        end
        go_idle();

        // Single channel 4, dwell 1: step and wrap every second cycle.
        set_in(1'b1, 1'b0, 8'd1, 8'h10);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            est = (k >= 3 && k % 2 == 1) ? 1 : 0;
            chk("one_sel", int'(sel), 4);
            chk("one_step", int'(step_pulse), est);
            chk("one_wrap", int'(wrap), est);
        end
        go_idle();

        // en dropped in the final dwell cycle: no step, straight to idle.
        set_in(1'b1, 1'b0, 8'd3, 8'hFF);
        repeat (4) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("drop_sel", int'(sel), 0);
        chk("drop_valid", int'(sel_valid), 0);
        chk("drop_step", int'(step_pulse), 0);
        repeat (2) @(negedge clk);

        // Current channel removed mid-dwell: dwell completes, search skips it.
        set_in(1'b1, 1'b0, 8'd3, 8'hFF);
        @(negedge clk);
        ch_mask = 8'hFE;
        repeat (3) @(negedge clk);
        chk("clr_hold", int'(sel), 0);
        chk("clr_hold_v", int'(sel_valid), 1);
        @(negedge clk);
        chk("clr_next", int'(sel), 1);
        chk("clr_step", int'(step_pulse), 1);
        repeat (9) @(negedge clk);
        go_idle();

        // Live dir and dwell changes, single-channel and empty-mask cases (model-checked).
        set_in(1'b1, 1'b0, 8'd1, 8'h69);
        repeat (6) @(negedge clk);
        dir = 1'b1;
        repeat (8) @(negedge clk);
        dwell = 8'd0;
        repeat (6) @(negedge clk);
        dir = 1'b0;
        repeat (5) @(negedge clk);
        ch_mask = 8'h40;
        repeat (4) @(negedge clk);
        ch_mask = 8'h00;
        @(negedge clk);
        chk("empty_valid", int'(sel_valid), 0);
        ch_mask = 8'h81;
        dwell = 8'd2;
        repeat (10) @(negedge clk);
        go_idle();

        // Asynchronous reset mid-dwell on channel 5, then restart at lowest channel.
        set_in(1'b1, 1'b0, 8'd5, 8'h24);
        repeat (9) @(negedge clk);
        chk("ar_pre_sel", int'(sel), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_sel", int'(sel), 0);
        chk("ar_valid", int'(sel_valid), 0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("ar_restart", int'(sel), 2);
        chk("ar_restart_v", int'(sel_valid), 1);
        repeat (4) @(negedge clk);
        go_idle();

`ifdef SCAN_FRAME_CNT_EN
        // Long two-channel run so the frame counter rolls over.
        set_in(1'b1, 1'b0, 8'd0, 8'h03);
        repeat (600) @(negedge clk);
        go_idle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
